stream_demux: RTL

STREAM_DEMUX -- requirements
Module: stream_demux

---
 rtl/stream_demux_pkg.sv | 17 +
 rtl/demux_lane.sv | 52 +++++
 rtl/stream_demux.sv | 91 +++++++++
 3 files changed

// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg
// Shared defaults and helpers for the stream demultiplexer.
//   DEF_DATA_W : default payload width in bits
//   DEF_N_OUT  : default number of output lanes
//   DEF_CNT_W  : default per-lane transfer counter width
//   sel_width  : lane-select width for a given lane count (never below 1)
package stream_demux_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_N_OUT  = 2;
    localparam int DEF_CNT_W  = 8;

    function automatic int sel_width(input int n_out);
        return (n_out > 2) ? $clog2(n_out) : 1;
    endfunction

endpackage

// File: rtl/demux_lane.sv
// demux_lane
// One output lane of the demultiplexer: a single-entry holding register
// with its valid bit and a wrapping count of completed transfers.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   load         : a beat for this lane is accepted this cycle
//   load_data    : payload of the accepted beat
//   lane_ready   : downstream acceptance for this lane
//   lane_valid   : lane holds a beat
//   lane_data    : held payload
//   lane_cnt     : number of completed transfers (wraps)
module demux_lane
    import stream_demux_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              lane_ready,
    output logic              lane_valid,
    output logic [DATA_W-1:0] lane_data,
    output logic [CNT_W-1:0]  lane_cnt
);

    logic xfer;

    assign xfer = lane_valid && lane_ready;

    // The top only asserts load when the lane is empty or draining this
    // cycle, so a load never overwrites an undelivered beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_valid <= 1'b0;
            lane_data  <= '0;
            lane_cnt   <= '0;
        end else begin
            if (load) begin
                lane_valid <= 1'b1;
                lane_data  <= load_data;
            end else if (xfer) begin
                lane_valid <= 1'b0;
            end
            if (xfer) begin
                lane_cnt <= lane_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_demux.sv
// stream_demux
// Routes a single valid/ready input stream to one of N_OUT output lanes
// chosen per beat by in_sel. Each lane buffers one beat and drains
// independently, so a stalled lane never blocks traffic to the others.
// Beats addressed to a non-existent lane are accepted, dropped, and
// latch the sticky err_sel flag.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : input beat present
//   in_ready   : input beat accepted when high together with in_valid
//   in_data    : input payload
//   in_sel     : destination lane of the input beat
//   out_valid  : per-lane beat present
//   out_ready  : per-lane downstream acceptance
//   out_data   : per-lane payload, lane k at [k*DATA_W +: DATA_W]
//   out_cnt    : per-lane completed transfers, lane k at [k*CNT_W +: CNT_W]
//   err_sel    : sticky out-of-range select flag
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int N_OUT  = DEF_N_OUT,
    parameter  int CNT_W  = DEF_CNT_W,
    localparam int SEL_W  = sel_width(N_OUT)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [SEL_W-1:0]        in_sel,
    output logic [N_OUT-1:0]        out_valid,
    input  logic [N_OUT-1:0]        out_ready,
    output logic [N_OUT*DATA_W-1:0] out_data,
    output logic [N_OUT*CNT_W-1:0]  out_cnt,
    output logic                    err_sel
);

    logic             sel_in_range;
    logic             sel_lane_free;
    logic             accept;
    logic [N_OUT-1:0] load;

    assign sel_in_range = ({1'b0, in_sel} < (SEL_W + 1)'(N_OUT));

    // Selected lane can take a beat if empty or draining this same cycle.
    // Walking the lanes avoids indexing out_valid with an out-of-range select.
    always_comb begin
        sel_lane_free = 1'b1;
        for (int k = 0; k < N_OUT; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_lane_free = !out_valid[k] || out_ready[k];
            end
        end
    end

    assign in_ready = sel_in_range ? sel_lane_free : 1'b1;
    assign accept   = in_valid && in_ready;

    always_comb begin
        load = '0;
        for (int k = 0; k < N_OUT; k++) begin
            load[k] = accept && (in_sel == SEL_W'(k));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sel <= 1'b0;
        end else if (accept && !sel_in_range) begin
            err_sel <= 1'b1;
        end
    end

    for (genvar g = 0; g < N_OUT; g++) begin : g_lane
        demux_lane #(
            .DATA_W (DATA_W),
            .CNT_W  (CNT_W)
        ) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .load       (load[g]),
            .load_data  (in_data),
            .lane_ready (out_ready[g]),
            .lane_valid (out_valid[g]),
            .lane_data  (out_data[g*DATA_W +: DATA_W]),
            .lane_cnt   (out_cnt[g*CNT_W +: CNT_W])
        );
    end

endmodule
